// File: rtl/regfile_write_scheduler.sv
// Arbitrates the register-file write port between WB and a multi-cycle unit, tracks MC-busy registers.
// Latency: granted write appears on rf_* one cycle after grant; mc_ready/hazard_stall are combinational.
// Backpressure: WB wins unless frozen; MC waits via mc_ready and forces wb_freeze after STARVE_LIMIT cycles.
module regfile_write_scheduler #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              mc_valid,
   output logic              mc_ready,
   input  logic [ADDR_W-1:0] mc_rd,
   input  logic [DATA_W-1:0] mc_data,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_rd,
   input  logic [ADDR_W-1:0] dec_rs1,
   input  logic [ADDR_W-1:0] dec_rs2,
   input  logic [ADDR_W-1:0] dec_rd,
   output logic              hazard_stall,
   output logic              wb_freeze,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0] rf_wdata
);

   localparam int NREG  = 1 << ADDR_W;
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   logic [NREG-1:0]   busy, busy_nxt;
   logic [CNT_W-1:0]  starve_cnt, starve_nxt;
   logic              grant_wb, grant_mc, issue_set;
   logic [ADDR_W-1:0] grant_rd;
   logic [DATA_W-1:0] grant_data;

   always_comb begin
      grant_wb     = wb_valid & ~wb_freeze;
      grant_mc     = mc_valid & ~grant_wb;
      mc_ready     = grant_mc;
      grant_rd     = grant_wb ? wb_rd   : mc_rd;
      grant_data   = grant_wb ? wb_data : mc_data;
      hazard_stall = busy[dec_rs1] | busy[dec_rs2] | (issue_valid & busy[dec_rd]) | wb_freeze;
      issue_set    = issue_valid & (issue_rd != '0) & ~hazard_stall;

      starve_nxt = '0;
      if (mc_valid && !grant_mc) begin
         starve_nxt = (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + CNT_W'(1);
      end

      // Clear before set so an issue to the register being retired keeps it busy.
      busy_nxt = busy;
      if (grant_mc) begin
         busy_nxt[mc_rd] = 1'b0;
      end
      if (issue_set) begin
         busy_nxt[issue_rd] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy       <= '0;
         starve_cnt <= '0;
         wb_freeze  <= 1'b0;
         rf_we      <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
      end else begin
         busy       <= busy_nxt;
         starve_cnt <= starve_nxt;
         if (grant_mc) begin
            wb_freeze <= 1'b0;
         end else if (starve_nxt == CNT_MAX) begin
            wb_freeze <= 1'b1;
         end
         // Writes to r0 are consumed but never reach the register file.
         rf_we <= (grant_wb | grant_mc) & (grant_rd != '0);
         if ((grant_wb || grant_mc) && grant_rd != '0) begin
            rf_waddr <= grant_rd;
            rf_wdata <= grant_data;
         end
      end
   end

endmodule
